// File: rtl/execute_memory_skid_register_pkg.sv
// execute_memory_skid_register_pkg: shared FSM encoding, default widths and EX/MEM payload types
package execute_memory_skid_register_pkg;
    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [2:0] funct3;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       jump;
    } em_ctrl_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0]       alu_result;
        logic [XLEN_DEF-1:0]       store_data;
        logic [XLEN_DEF-1:0]       pc_plus4;
        logic [REG_ADDR_W_DEF-1:0] rd;
        em_ctrl_t                  ctrl;
    } em_payload_t;
endpackage

// File: rtl/execute_memory_skid_register_skid.sv
// pipe_skid_buffer: generic two-entry skid buffer (main drives output, skid absorbs one op of backpressure)
module pipe_skid_buffer
    import execute_memory_skid_register_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    skid_state_e r_state, w_state_next;
    logic [W-1:0] r_main, r_skid, w_main_next, w_skid_next;
    logic         w_accept, w_drain;

    // ready comes straight from the state register, so it never depends on i_ready
    assign o_valid  = (r_state == ST_BUSY) || (r_state == ST_FULL);
    assign o_ready  = r_state != ST_FULL;
    assign o_data   = r_main;
    assign w_accept = i_valid && o_ready;
    assign w_drain  = o_valid && i_ready;

    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;
        case (r_state)
            ST_EMPTY: if (w_accept) begin
                w_state_next = ST_BUSY;
                w_main_next  = i_data;
            end
            ST_BUSY: if (w_accept && w_drain) begin
                w_main_next = i_data;
            end else if (w_accept) begin
                w_state_next = ST_FULL;
                w_skid_next  = i_data;
            end else if (w_drain) begin
                w_state_next = ST_EMPTY;
            end
            ST_FULL: if (w_drain) begin
                w_state_next = ST_BUSY;
                w_main_next  = r_skid;
            end
            default: w_state_next = ST_EMPTY;
        endcase
        if (i_flush) w_state_next = ST_EMPTY;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_next;
            r_main  <= w_main_next;
            r_skid  <= w_skid_next;
        end
    end
endmodule

// File: rtl/execute_memory_skid_register.sv
// execute_memory_skid_register: EX->MEM skid register with EX/MEM forwarding and load-use detection
// Define PIPE_PERF_CNT_EN to add saturating stall/bubble/flush counters.
module execute_memory_skid_register
    import execute_memory_skid_register_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [XLEN-1:0]       alu_result_i,
    input  logic [XLEN-1:0]       store_data_i,
    input  logic [XLEN-1:0]       pc_plus4_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [2:0]            funct3_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic                  mem_to_reg_i,
    input  logic                  reg_write_i,
    input  logic                  jump_i,
    output logic                  em_valid_o,
    input  logic                  em_ready_i,
    output logic [XLEN-1:0]       em_alu_result_o,
    output logic [XLEN-1:0]       em_store_data_o,
    output logic [XLEN-1:0]       em_pc_plus4_o,
    output logic [REG_ADDR_W-1:0] em_rd_o,
    output logic [2:0]            em_funct3_o,
    output logic                  em_mem_read_o,
    output logic                  em_mem_write_o,
    output logic                  em_mem_to_reg_o,
    output logic                  em_reg_write_o,
    output logic                  em_jump_o,
    input  logic [REG_ADDR_W-1:0] de_rs1_i,
    input  logic [REG_ADDR_W-1:0] de_rs2_i,
    output logic                  fwd_valid_o,
    output logic [REG_ADDR_W-1:0] fwd_rd_o,
    output logic [XLEN-1:0]       fwd_data_o,
    output logic                  load_use_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      bubble_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
`endif
);
    localparam int PW = 3 * XLEN + REG_ADDR_W + $bits(em_ctrl_t);

    em_ctrl_t        w_in_ctrl, w_out_ctrl;
    logic [PW-1:0]   w_in_payload, w_out_payload;

    // x0 is never written, so it must never look like a forwarding source
    assign w_in_ctrl = '{
        funct3:     funct3_i,
        mem_read:   mem_read_i,
        mem_write:  mem_write_i,
        mem_to_reg: mem_to_reg_i,
        reg_write:  reg_write_i && (rd_i != '0),
        jump:       jump_i
    };
    assign w_in_payload = {alu_result_i, store_data_i, pc_plus4_i, rd_i, w_in_ctrl};

    pipe_skid_buffer #(.W(PW)) u_skid (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_flush (flush_i),
        .i_valid (ex_valid_i),
        .o_ready (ex_ready_o),
        .i_data  (w_in_payload),
        .o_valid (em_valid_o),
        .i_ready (em_ready_i),
        .o_data  (w_out_payload)
    );

    assign {em_alu_result_o, em_store_data_o, em_pc_plus4_o, em_rd_o, w_out_ctrl} = w_out_payload;
    assign em_funct3_o     = w_out_ctrl.funct3;
    assign em_mem_read_o   = w_out_ctrl.mem_read;
    assign em_mem_write_o  = w_out_ctrl.mem_write;
    assign em_mem_to_reg_o = w_out_ctrl.mem_to_reg;
    assign em_reg_write_o  = w_out_ctrl.reg_write;
    assign em_jump_o       = w_out_ctrl.jump;

    assign fwd_valid_o = em_valid_o && em_reg_write_o;
    assign fwd_rd_o    = em_rd_o;
    assign fwd_data_o  = em_jump_o ? em_pc_plus4_o : em_alu_result_o;
    assign load_use_o  = em_valid_o && em_mem_read_o && (em_rd_o != '0) &&
                         ((em_rd_o == de_rs1_i) || (em_rd_o == de_rs2_i));

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt, r_flush_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (ex_valid_i && !ex_ready_o && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (!em_valid_o && em_ready_i && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            if (flush_i && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
    assign flush_cnt_o  = r_flush_cnt;
`endif
endmodule

// File: tb/tb_execute_memory_skid_register.sv
// tb_execute_memory_skid_register: scoreboard bench for the EX/MEM skid register
module tb_execute_memory_skid_register;
    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] st;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mr;
        logic        mw;
        logic        mtr;
        logic        rw;
        logic        j;
    } op_t;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, ex_valid = 1'b0, em_ready = 1'b0;
    logic        ex_ready, em_valid;
    logic [31:0] alu_result = '0, store_data = '0, pc_plus4 = '0;
    logic [4:0]  rd = '0, de_rs1 = '0, de_rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0, reg_write = 1'b0, jump = 1'b0;
    logic [31:0] em_alu_result, em_store_data, em_pc_plus4, fwd_data;
    logic [4:0]  em_rd, fwd_rd;
    logic [2:0]  em_funct3;
    logic        em_mem_read, em_mem_write, em_mem_to_reg, em_reg_write, em_jump;
    logic        fwd_valid, load_use;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
`endif

    op_t q[$];
    int  checks = 0, errors = 0, popped = 0;

    execute_memory_skid_register dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .ex_valid_i      (ex_valid),
        .ex_ready_o      (ex_ready),
        .alu_result_i    (alu_result),
        .store_data_i    (store_data),
        .pc_plus4_i      (pc_plus4),
        .rd_i            (rd),
        .funct3_i        (funct3),
        .mem_read_i      (mem_read),
        .mem_write_i     (mem_write),
        .mem_to_reg_i    (mem_to_reg),
        .reg_write_i     (reg_write),
        .jump_i          (jump),
        .em_valid_o      (em_valid),
        .em_ready_i      (em_ready),
        .em_alu_result_o (em_alu_result),
        .em_store_data_o (em_store_data),
        .em_pc_plus4_o   (em_pc_plus4),
        .em_rd_o         (em_rd),
        .em_funct3_o     (em_funct3),
        .em_mem_read_o   (em_mem_read),
        .em_mem_write_o  (em_mem_write),
        .em_mem_to_reg_o (em_mem_to_reg),
        .em_reg_write_o  (em_reg_write),
        .em_jump_o       (em_jump),
        .de_rs1_i        (de_rs1),
        .de_rs2_i        (de_rs2),
        .fwd_valid_o     (fwd_valid),
        .fwd_rd_o        (fwd_rd),
        .fwd_data_o      (fwd_data),
        .load_use_o      (load_use)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt_o     (stall_cnt),
        .bubble_cnt_o    (bubble_cnt),
        .flush_cnt_o     (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Monitor/scoreboard: pops on every MEM handshake, pushes on every EX handshake
    always @(negedge clk) begin
        op_t got, e;
        if (rst) q.delete();
        else begin
            if (em_valid && em_ready) begin
                got = '{em_alu_result, em_store_data, em_pc_plus4, em_rd, em_funct3,
                        em_mem_read, em_mem_write, em_mem_to_reg, em_reg_write, em_jump};
                if (q.size() == 0) chk("unexpected_op", 128'(got), 128'(0));
                else begin
                    e = q.pop_front();
                    popped++;
                    chk("em_payload", 128'(got), 128'(e));
                end
            end
            if (flush) q.delete();
            else if (ex_valid && ex_ready) begin
                e = '{alu_result, store_data, pc_plus4, rd, funct3,
                      mem_read, mem_write, mem_to_reg, reg_write && (rd != 5'd0), jump};
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] r,
                         input logic mr, input logic mw, input logic rw, input logic j,
                         input logic [31:0] pc4);
        ex_valid   = v;
        alu_result = alu;
        store_data = alu ^ 32'hFFFF_0000;
        pc_plus4   = pc4;
        rd         = r;
        funct3     = r[2:0];
        mem_read   = mr;
        mem_write  = mw;
        mem_to_reg = mr;
        reg_write  = rw;
        jump       = j;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_em_valid", 128'(em_valid), 128'(0));
        chk("rst_ex_ready", 128'(ex_ready), 128'(1));
        chk("rst_em_alu", 128'(em_alu_result), 128'(0));
        chk("rst_fwd_valid", 128'(fwd_valid), 128'(0));
        rst = 1'b0;

        // stream at full rate
        em_ready = 1'b1;
        drive(1, 32'h10, 5'd3, 0, 0, 1, 0, 32'h4);
        step();
        chk("stream_em_alu0", 128'(em_alu_result), 128'(32'h10));
        chk("stream_ready0", 128'(ex_ready), 128'(1));
        drive(1, 32'h20, 5'd4, 0, 1, 0, 0, 32'h8);
        step();
        chk("stream_em_alu1", 128'(em_alu_result), 128'(32'h20));
        chk("stream_ready1", 128'(ex_ready), 128'(1));
        drive(1, 32'h30, 5'd6, 0, 0, 1, 0, 32'hC);
        step();
        chk("stream_em_alu2", 128'(em_alu_result), 128'(32'h30));
        chk("stream_valid2", 128'(em_valid), 128'(1));
        ex_valid = 1'b0;
        step();
        chk("stream_drained", 128'(em_valid), 128'(0));

        // backpressure fills both entries
        em_ready = 1'b0;
        drive(1, 32'hA, 5'd7, 0, 0, 1, 0, 32'h10);
        step();
        drive(1, 32'hB, 5'd8, 0, 0, 1, 0, 32'h14);
        step();
        ex_valid = 1'b0;
        chk("full_ex_ready", 128'(ex_ready), 128'(0));
        chk("full_em_alu", 128'(em_alu_result), 128'(32'hA));
        em_ready = 1'b1;
        step();
        chk("release_em_alu", 128'(em_alu_result), 128'(32'hB));
        step();
        chk("release_empty", 128'(em_valid), 128'(0));

        // flush while full, with a new op offered in the same cycle
        em_ready = 1'b0;
        drive(1, 32'h1, 5'd9, 0, 0, 1, 0, 32'h18);
        step();
        drive(1, 32'h2, 5'd10, 0, 0, 1, 0, 32'h1C);
        step();
        drive(1, 32'h3, 5'd11, 0, 0, 1, 0, 32'h20);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        ex_valid = 1'b0;
        chk("flush_em_valid", 128'(em_valid), 128'(0));
        chk("flush_ex_ready", 128'(ex_ready), 128'(1));
        em_ready = 1'b1;
        repeat (3) step();

        // load-use hazard and x0 suppression
        em_ready = 1'b0;
        de_rs1   = 5'd7;
        de_rs2   = 5'd5;
        drive(1, 32'h200, 5'd5, 1, 0, 1, 0, 32'h24);
        step();
        ex_valid = 1'b0;
        chk("load_use_rs2", 128'(load_use), 128'(1));
        chk("load_fwd_valid", 128'(fwd_valid), 128'(1));
        chk("load_fwd_rd", 128'(fwd_rd), 128'(5));
        de_rs2 = 5'd6;
        #1;
        chk("load_use_nomatch", 128'(load_use), 128'(0));
        em_ready = 1'b1;
        step();
        em_ready = 1'b0;
        de_rs1   = 5'd0;
        de_rs2   = 5'd0;
        drive(1, 32'h300, 5'd0, 1, 0, 1, 0, 32'h28);
        step();
        ex_valid = 1'b0;
        chk("load_x0_use", 128'(load_use), 128'(0));
        chk("load_x0_fwd", 128'(fwd_valid), 128'(0));
        em_ready = 1'b1;
        step();

        // jump forwards its link value
        em_ready = 1'b0;
        drive(1, 32'h55, 5'd1, 0, 0, 1, 1, 32'h104);
        step();
        ex_valid = 1'b0;
        chk("jump_fwd_data", 128'(fwd_data), 128'(32'h104));
        chk("jump_fwd_valid", 128'(fwd_valid), 128'(1));
        chk("jump_fwd_rd", 128'(fwd_rd), 128'(1));
        em_ready = 1'b1;
        step();
        step();
        chk("ops_delivered", 128'(popped), 128'(8));
        chk("queue_empty", 128'(q.size()), 128'(0));

        // asynchronous reset while full
        em_ready = 1'b0;
        drive(1, 32'h7, 5'd12, 1, 0, 1, 0, 32'h2C);
        step();
        drive(1, 32'h8, 5'd13, 0, 0, 1, 0, 32'h30);
        step();
        ex_valid = 1'b0;
        chk("pre_rst_full", 128'(ex_ready), 128'(0));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_em_valid", 128'(em_valid), 128'(0));
        chk("arst_ex_ready", 128'(ex_ready), 128'(1));
        chk("arst_em_alu", 128'(em_alu_result), 128'(0));
        chk("arst_em_ctrl", 128'({em_mem_read, em_reg_write, em_rd}), 128'(0));
        chk("arst_load_use", 128'(load_use), 128'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        step();
        chk("post_rst_empty", 128'(em_valid), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
